// File: rtl/adc_serial_rx.sv
// adc_serial_rx: receiver for two serial ADCs that share one sclk/cs_n pair.
// Each frame is 16 sclk periods long. Bits 2..13 (MSB first) form the sample,
// and both channels are published together with a one-cycle data_valid pulse.
// Optional build macro ADC_FRAME_CHECK_EN: when defined, nonzero framing bits
// (0, 1, 14, 15) on either channel pulse frame_err alongside data_valid.
// When it is undefined, frame_err is tied low.
module adc_serial_rx #(
    parameter int DSIZE        = 12,
    parameter int CLK_DIV      = 2,
    parameter int QUIET_CYCLES = 4
) (
    input  logic             CLK100MHz,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sdata_ch1,
    input  logic             sdata_ch2,
    output logic             sclk,
    output logic             cs_n,
    output logic [DSIZE-1:0] ch1_data,
    output logic [DSIZE-1:0] ch2_data,
    output logic             data_valid,
    output logic             busy,
    output logic             frame_err
);

`ifdef ADC_FRAME_CHECK_EN
    // All of bits 0..14 are kept so that the framing bits can be inspected.
    localparam int SHIFT_W = 15;
`else
    // Only bits 2..14 are kept, because the leading framing bits are never used.
    localparam int SHIFT_W = 13;
`endif

    localparam logic [7:0] DIV_END   = 8'(CLK_DIV - 1);
    localparam logic [7:0] QUIET_END = 8'(QUIET_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        QUIET
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [7:0]         div_cnt;
    logic [7:0]         div_next;
    logic [4:0]         edge_cnt;
    logic [4:0]         edge_next;
    logic [7:0]         quiet_cnt;
    logic [7:0]         quiet_next;
    logic [SHIFT_W-1:0] shift1;
    logic [SHIFT_W-1:0] shift1_next;
    logic [SHIFT_W-1:0] shift2;
    logic [SHIFT_W-1:0] shift2_next;
    logic               sclk_next;
    logic               cs_n_next;
    logic [DSIZE-1:0]   ch1_next;
    logic [DSIZE-1:0]   ch2_next;
    logic               valid_next;
    logic               div_done;
    logic               last_toggle;

    // The 32nd sclk toggle is always a rising edge. It carries bit 15, so the
    // sample is taken from the shift register before that final shift.
    assign div_done    = (div_cnt == DIV_END);
    assign last_toggle = div_done && (edge_cnt == 5'd31);
    assign busy        = (state != IDLE);

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_next  = state;
        div_next    = div_cnt;
        edge_next   = edge_cnt;
        quiet_next  = quiet_cnt;
        shift1_next = shift1;
        shift2_next = shift2;
        sclk_next   = sclk;
        cs_n_next   = cs_n;
        ch1_next    = ch1_data;
        ch2_next    = ch2_data;
        valid_next  = 1'b0;
        case (state)
            IDLE: begin
                sclk_next = 1'b1;
                cs_n_next = 1'b1;
                div_next  = 8'd0;
                edge_next = 5'd0;
                if (en) begin
                    state_next = CONV;
                    cs_n_next  = 1'b0;
                end
            end
            CONV: begin
                if (div_done) begin
                    div_next  = 8'd0;
                    edge_next = edge_cnt + 5'd1;
                    sclk_next = ~sclk;
                    if (!sclk) begin
                        shift1_next = {shift1[SHIFT_W-2:0], sdata_ch1};
                        shift2_next = {shift2[SHIFT_W-2:0], sdata_ch2};
                    end
                    if (last_toggle) begin
                        state_next = QUIET;
                        cs_n_next  = 1'b1;
                        sclk_next  = 1'b1;
                        edge_next  = 5'd0;
                        quiet_next = 8'd0;
                        ch1_next   = DSIZE'(shift1[12:1]);
                        ch2_next   = DSIZE'(shift2[12:1]);
                        valid_next = 1'b1;
                    end
                end else begin
                    div_next = div_cnt + 8'd1;
                end
            end
            QUIET: begin
                cs_n_next = 1'b1;
                sclk_next = 1'b1;
                if (quiet_cnt == QUIET_END) begin
                    quiet_next = 8'd0;
                    div_next   = 8'd0;
                    edge_next  = 5'd0;
                    if (en) begin
                        state_next = CONV;
                        cs_n_next  = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    quiet_next = quiet_cnt + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, counter and output registers. sclk and cs_n come straight from flops.
    always_ff @(posedge CLK100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div_cnt    <= 8'd0;
            edge_cnt   <= 5'd0;
            quiet_cnt  <= 8'd0;
            shift1     <= '0;
            shift2     <= '0;
            sclk       <= 1'b1;
            cs_n       <= 1'b1;
            ch1_data   <= '0;
            ch2_data   <= '0;
            data_valid <= 1'b0;
        end else begin
            state      <= state_next;
            div_cnt    <= div_next;
            edge_cnt   <= edge_next;
            quiet_cnt  <= quiet_next;
            shift1     <= shift1_next;
            shift2     <= shift2_next;
            sclk       <= sclk_next;
            cs_n       <= cs_n_next;
            ch1_data   <= ch1_next;
            ch2_data   <= ch2_next;
            data_valid <= valid_next;
        end
    end

`ifdef ADC_FRAME_CHECK_EN
    logic framing_bad;

    // Framing bits of the arriving frame: bits 0 and 1 (shift[14:13]), bit 14 (shift[0]) and bit 15 (live input).
    assign framing_bad = shift1[14] | shift1[13] | shift1[0] | sdata_ch1 |
                         shift2[14] | shift2[13] | shift2[0] | sdata_ch2;

    // Framing error pulse, aligned with the data_valid of the same frame.
    always_ff @(posedge CLK100MHz or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= (state == CONV) && last_toggle && framing_bad;
        end
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule
